// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: FSM state encoding,
// requester count and the default-width operation bundle.
package alu_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] srca;
        logic [DATA_W-1:0] srcb;
        logic [OP_W-1:0]   op;
    } alu_req_t;

    function automatic logic [NUM_REQ-1:0] onehot(logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle between the requesters/ALU environment (master) and the arbiter (slave).
// The master side also hosts the external ALU that consumes alu_* and returns alu_result.
interface alu_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [DATA_WIDTH-1:0]    req_srca0;
    logic [DATA_WIDTH-1:0]    req_srca1;
    logic [DATA_WIDTH-1:0]    req_srcb0;
    logic [DATA_WIDTH-1:0]    req_srcb1;
    logic [OPCODE_LENGTH-1:0] req_op0;
    logic [OPCODE_LENGTH-1:0] req_op1;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_result;
    logic [DATA_WIDTH-1:0]    alu_srca;
    logic [DATA_WIDTH-1:0]    alu_srcb;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic                     busy;

    modport master (
        output req_valid, req_srca0, req_srca1, req_srcb0, req_srcb1, req_op0, req_op1,
        output rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_result, alu_srca, alu_srcb, alu_op, busy
    );

    modport slave (
        input  req_valid, req_srca0, req_srca1, req_srcb0, req_srcb1, req_op0, req_op1,
        input  rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_result, alu_srca, alu_srcb, alu_op, busy
    );

endinterface

// File: rtl/alu_arb_pick.sv
// Combinational winner selection for the ALU arbiter.
// ALU_ARB_ROUND_ROBIN_EN: ties alternate away from last_grant; otherwise requester 0 wins ties.
module alu_arb_pick
    import alu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = req_valid;
        if (&req_valid) grant = onehot(!last_grant);
    end
`else
    // last_grant is still tracked by the top but has no say in fixed priority
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = req_valid;
        if (&req_valid) grant = onehot(1'b0);
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: accept, register
// operands, capture result, return it with backpressure. Tie policy via ALU_ARB_ROUND_ROBIN_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EXEC = EXEC;
    localparam logic [1:0] S_RESP = RESP;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    srca;
        logic [DATA_WIDTH-1:0]    srcb;
        logic [OPCODE_LENGTH-1:0] op;
    } req_t;

    logic [1:0]            state_q;
    logic                  owner_q;
    logic                  last_grant_q;
    req_t                  opnd_q;
    logic [DATA_WIDTH-1:0] result_q;

    logic [NUM_REQ-1:0]    grant;
    req_t                  req [NUM_REQ];
    req_t                  win;
    logic                  accept;
    logic                  rsp_done;

    assign req[0] = '{srca: bus.req_srca0, srcb: bus.req_srcb0, op: bus.req_op0};
    assign req[1] = '{srca: bus.req_srca1, srcb: bus.req_srcb1, op: bus.req_op1};

    alu_arb_pick u_pick (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign win      = req[grant[1]];
    assign accept   = (state_q == S_IDLE) && (|grant);
    // Only the owner's rsp_ready can retire the response
    assign rsp_done = (state_q == S_RESP) && bus.rsp_ready[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            opnd_q       <= '0;
            result_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    opnd_q       <= win;
                    owner_q      <= grant[1];
                    last_grant_q <= grant[1];
                    state_q      <= S_EXEC;
                end
                S_EXEC: begin
                    result_q <= bus.alu_result;
                    state_q  <= S_RESP;
                end
                S_RESP: if (rsp_done) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE) ? grant : '0;
    assign bus.rsp_valid  = (state_q == S_RESP) ? onehot(owner_q) : '0;
    assign bus.rsp_result = result_q;
    assign bus.alu_srca   = opnd_q.srca;
    assign bus.alu_srcb   = opnd_q.srcb;
    assign bus.alu_op     = opnd_q.op;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer that shares one combinational `alu` instance between execute-side clients, for example the main execute path and a branch/address helper. It accepts an operation per requester over valid/ready, selects a winner, registers the operands onto the ALU port, captures the result, and returns it to the owning requester with valid/ready backpressure. It sits between the requesters and a single external `alu` instance.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `req_valid`  in  2  request valid, bit i = requester i
- `req_ready`  out  2  request accepted this cycle, one-hot or zero
- `req_srca0`, `req_srca1`  in  DATA_WIDTH  operand A per requester
- `req_srcb0`, `req_srcb1`  in  DATA_WIDTH  operand B per requester
- `req_op0`, `req_op1`  in  OPCODE_LENGTH  ALU operation per requester
- `rsp_valid`  out  2  response valid, bit i = requester i, one-hot or zero
- `rsp_ready`  in  2  requester i accepts its response
- `rsp_result`  out  DATA_WIDTH  result, shared by both requesters, qualified by `rsp_valid`
- `alu_srca`, `alu_srcb`  out  DATA_WIDTH  registered operands to the ALU
- `alu_op`  out  OPCODE_LENGTH  registered operation to the ALU
- `alu_result`  in  DATA_WIDTH  combinational ALU output
- `busy`  out  1  high in any state other than IDLE

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` bit is set, pick a winner and drive its `req_ready` high combinationally.
  - On the clock edge, latch the winner's srca/srcb/op into the operand registers and its index into `owner`, then go to EXEC.
  - If no request is valid, stay in IDLE with `req_ready` = 0.
- **EXEC:**
  - The operand registers drive the ALU.
  - `alu_result` is captured into `result_q` and the FSM goes to RESP.
  - `req_ready` = 0.
- **RESP:**
  - `rsp_valid[owner]` = 1 and `rsp_result` = `result_q`.
  - `rsp_result` and `rsp_valid` hold stable until `rsp_ready[owner]` is high.
  - On that handshake, go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
  - `req_ready` = 0.
- **Winner selection** uses `last_grant`, a 1-bit register that is updated on each accept.
  - Single requester valid: that requester wins.
  - Both valid: arbitration per Configuration.
- **Requests:** the arbiter never inspects opcodes and passes any `OPCODE_LENGTH` value through to the ALU. A requester must hold srca/srcb/op stable while `req_valid` is high and `req_ready` is low.
- **Width rules:** no arithmetic happens inside the block. Results are passed through at DATA_WIDTH unchanged.

## Timing
- **Reset values:**
  - `req_ready` = 0, `rsp_valid` = 0 and `busy` = 0.
  - `rsp_result`, `alu_srca`, `alu_srcb` and `alu_op` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
- **Latency:** request accepted at edge N, captured at edge N+1, `rsp_valid` high in cycle N+2.
- **Throughput:** at best one operation per 3 cycles. A new accept is possible only in IDLE, at the earliest the cycle after a response handshake.
- **Backpressure:** RESP is held indefinitely while `rsp_ready[owner]` = 0, and no new request is accepted during that time.
- **Reset mid-operation:** asserting `rst_n` low in any state returns the FSM to IDLE asynchronously. The in-flight operation is dropped and no response is issued.
- **Withdrawn request:** a `req_valid` deasserted in IDLE before acceptance has no effect.

## Configuration
- Macro: `ALU_ARB_ROUND_ROBIN_EN`.
- **Defined:** on a tie, the requester not equal to `last_grant` wins, so back-to-back ties alternate 0, 1, 0, 1.
- **Undefined:** fixed priority, requester 0 always wins a tie. `last_grant` is still updated but not used.

## Structure
- **Shared package `alu_arb_pkg`:**
  - state enum `alu_arb_state_t` {IDLE, EXEC, RESP}
  - `NUM_REQ` = 2
  - `alu_req_t` struct {srca, srcb, op}
- **Sub-module `alu_arb_pick`:** combinational winner selection. It takes `req_valid` and `last_grant` and produces a one-hot grant, and contains the `ALU_ARB_ROUND_ROBIN_EN` conditional.
- **Top-level:** instantiated alongside one `alu` instance, with `alu_srca`/`alu_srcb`/`alu_op` wired to its inputs and its `ALUResult` wired back to `alu_result`.

## Test plan
- **ADD, single requester:** requester 0 sends srca=5, srcb=7, op=4'b0010 with `rsp_ready[0]`=1 → `req_ready[0]` in cycle 0, `rsp_valid[0]` in cycle 2 with `rsp_result`=12, `busy` low in cycle 3.
- **SUB, requester 1:** srca=3, srcb=5, op=4'b0110 → `rsp_valid[1]` with `rsp_result`=32'hFFFFFFFE, and `rsp_valid[0]` stays 0.
- **Tie with macro defined:** both requesters continuously valid, requester 0 AND 32'hF0F0 & 32'hFF00, requester 1 OR 32'h1 | 32'h2 → grants alternate 0, 1, 0, 1 with results 32'hF000 and 32'h3. With the macro undefined → requester 0 is granted every time.
- **Backpressure:** `rsp_ready[0]`=0 for 5 cycles in RESP → `rsp_valid[0]` and `rsp_result` stable, `req_ready`=0 despite `req_valid[1]`=1. Releasing `rsp_ready[0]` → IDLE, then requester 1 is accepted.
- **Reset mid-operation:** `rst_n` low during EXEC → all outputs 0 immediately and no `rsp_valid` after release. The next request completes normally with `last_grant` at its reset value.
- **Opcode passthrough:** unmapped op 4'b0011 → `alu_op`=4'b0011 in EXEC and `rsp_result`=0, matching the ALU default.
